// File: rtl/mem_arbiter.sv
`default_nettype none
// =============================================================================
// Module   : mem_arbiter
// Purpose  : Two-port arbiter/sequencer for the 4K x 8 single-port memory.
//            Define MEM_ARB_RR_EN for round-robin, else port 0 has priority.
// Revision : 1.0
// =============================================================================
module mem_arbiter #(
  parameter int AW = 12,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  output logic          p0_gnt,
  output logic          p0_rvalid,
  output logic [DW-1:0] p0_rdata,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic          p1_gnt,
  output logic          p1_rvalid,
  output logic [DW-1:0] p1_rdata,
  output logic          mem_we,
  output logic          mem_re,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_in,
  input  logic [DW-1:0] mem_out,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RDATA  = 2'd2
  } state_t;

  state_t        r_state,     w_state_nx;
  logic          r_win,       w_win_nx;
  logic          r_p0_gnt,    w_p0_gnt_nx;
  logic          r_p1_gnt,    w_p1_gnt_nx;
  logic          r_p0_rvalid, w_p0_rvalid_nx;
  logic          r_p1_rvalid, w_p1_rvalid_nx;
  logic [DW-1:0] r_p0_rdata,  w_p0_rdata_nx;
  logic [DW-1:0] r_p1_rdata,  w_p1_rdata_nx;
  logic          r_mem_we,    w_mem_we_nx;
  logic          r_mem_re,    w_mem_re_nx;
  logic [AW-1:0] r_mem_addr,  w_mem_addr_nx;
  logic [DW-1:0] r_mem_in,    w_mem_in_nx;
  logic          r_busy,      w_busy_nx;

  logic          w_any_req;
  logic          w_pick1;
  logic          w_sel_we;

  assign w_any_req = p0_req | p1_req;
  assign w_sel_we  = w_pick1 ? p1_we : p0_we;

`ifdef MEM_ARB_RR_EN
  // r_last holds the port granted most recently; resets to 1 so port 0 wins first
  logic r_last;

  assign w_pick1 = p1_req & (~p0_req | ~r_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= 1'b1;
    end else if (r_state == IDLE && w_any_req) begin
      r_last <= w_pick1;
    end
  end
`else
  assign w_pick1 = p1_req & ~p0_req;
`endif

  always_comb begin
    w_state_nx     = r_state;
    w_win_nx       = r_win;
    w_p0_gnt_nx    = 1'b0;
    w_p1_gnt_nx    = 1'b0;
    w_p0_rvalid_nx = 1'b0;
    w_p1_rvalid_nx = 1'b0;
    w_p0_rdata_nx  = r_p0_rdata;
    w_p1_rdata_nx  = r_p1_rdata;
    w_mem_we_nx    = 1'b0;
    w_mem_re_nx    = 1'b0;
    w_mem_addr_nx  = r_mem_addr;
    w_mem_in_nx    = r_mem_in;
    w_busy_nx      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any_req) begin
          w_state_nx    = ACCESS;
          w_win_nx      = w_pick1;
          w_p0_gnt_nx   = ~w_pick1;
          w_p1_gnt_nx   = w_pick1;
          w_mem_addr_nx = w_pick1 ? p1_addr : p0_addr;
          w_mem_in_nx   = w_pick1 ? p1_wdata : p0_wdata;
          w_mem_we_nx   = w_sel_we;
          w_mem_re_nx   = ~w_sel_we;
          w_busy_nx     = 1'b1;
        end
      end
      ACCESS: begin
        // memory samples the command at the end of this cycle
        if (r_mem_re) begin
          w_state_nx = RDATA;
          w_busy_nx  = 1'b1;
        end else begin
          w_state_nx = IDLE;
        end
      end
      RDATA: begin
        w_state_nx = IDLE;
        if (r_win) begin
          w_p1_rdata_nx  = mem_out;
          w_p1_rvalid_nx = 1'b1;
        end else begin
          w_p0_rdata_nx  = mem_out;
          w_p0_rvalid_nx = 1'b1;
        end
      end
      default: begin
        w_state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_win       <= 1'b0;
      r_p0_gnt    <= 1'b0;
      r_p1_gnt    <= 1'b0;
      r_p0_rvalid <= 1'b0;
      r_p1_rvalid <= 1'b0;
      r_p0_rdata  <= '0;
      r_p1_rdata  <= '0;
      r_mem_we    <= 1'b0;
      r_mem_re    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_in    <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_win       <= w_win_nx;
      r_p0_gnt    <= w_p0_gnt_nx;
      r_p1_gnt    <= w_p1_gnt_nx;
      r_p0_rvalid <= w_p0_rvalid_nx;
      r_p1_rvalid <= w_p1_rvalid_nx;
      r_p0_rdata  <= w_p0_rdata_nx;
      r_p1_rdata  <= w_p1_rdata_nx;
      r_mem_we    <= w_mem_we_nx;
      r_mem_re    <= w_mem_re_nx;
      r_mem_addr  <= w_mem_addr_nx;
      r_mem_in    <= w_mem_in_nx;
      r_busy      <= w_busy_nx;
    end
  end

  assign p0_gnt    = r_p0_gnt;
  assign p1_gnt    = r_p1_gnt;
  assign p0_rvalid = r_p0_rvalid;
  assign p1_rvalid = r_p1_rvalid;
  assign p0_rdata  = r_p0_rdata;
  assign p1_rdata  = r_p1_rdata;
  assign mem_we    = r_mem_we;
  assign mem_re    = r_mem_re;
  assign mem_addr  = r_mem_addr;
  assign mem_in    = r_mem_in;
  assign busy      = r_busy;

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter and sequencer for the 4K x 8 single-port `memory` block. It accepts read/write requests from two requesters, for example instruction fetch on port 0 and data/load-store on port 1. It serialises the requests onto the memory's `we`/`re`/`addr`/`in` pins, captures `out`, and returns read data to the requester that issued the read. It sits between the core and `memory`; no other block drives the memory pins.

## Interface
- `AW`, 12: address width; matches `memory` addr.
- `DW`, 8: data width; matches `memory` in/out.
- `clk` in 1: single clock, rising edge; shared with `memory`.
- `rst_n` in 1: asynchronous, active-low reset.
- `p0_req` / `p1_req` in 1: request; held with command fields stable until `pN_gnt`.
- `p0_we` / `p1_we` in 1: 1 = write, 0 = read.
- `p0_addr` / `p1_addr` in AW: request address.
- `p0_wdata` / `p1_wdata` in DW: write data.
- `p0_gnt` / `p1_gnt` out 1: one-cycle pulse; command accepted.
- `p0_rvalid` / `p1_rvalid` out 1: one-cycle pulse; `pN_rdata` valid.
- `p0_rdata` / `p1_rdata` out DW: read data; holds until that port's next read completes.
- `mem_we` out 1: to `memory.we`.
- `mem_re` out 1: to `memory.re`.
- `mem_addr` out AW: to `memory.addr`.
- `mem_in` out DW: to `memory.in`.
- `mem_out` in DW: from `memory.out`; valid in the cycle after the `mem_re` cycle.
- `busy` out 1: high whenever the FSM is not in IDLE.

## Operation
- All outputs are registered.
- Reset value of every output is 0, including all `mem_*`, `gnt`, `rvalid`, `rdata` and `busy`.
- FSM states: IDLE, ACCESS, RDATA. Reset state is IDLE.
- IDLE:
  - If any `pN_req` is high, select a winner.
  - Load `mem_addr` from the winner's address and `mem_in` from its wdata.
  - Set `mem_we` to the winner's `we`, and `mem_re` to the inverse of its `we`.
  - Pulse the winner's `gnt` and record the winner.
  - Go to ACCESS.
  - With no request, all `mem_*` controls stay 0.
- ACCESS:
  - Memory samples the command at the end of this cycle.
  - Clear `mem_we`/`mem_re` at the end of the cycle.
  - Write: go to IDLE.
  - Read: go to RDATA.
- RDATA:
  - Capture `mem_out` into the recorded winner's `rdata`.
  - Pulse that port's `rvalid`.
  - Go to IDLE.
- Requests arriving while `busy` are not sampled. They wait, held stable by the requester, until IDLE.
- A requester drops `req`, or presents a new command, in the cycle after it sees `gnt`. The arbiter samples that port again only in IDLE.
- `mem_addr` and `mem_in` hold their last value outside ACCESS. Only `mem_we`/`mem_re` return to 0.
- The other port's `rdata` is never disturbed by a read completion.

## Timing
- Cycle 0 (IDLE, `req` high) -> cycle 1: `gnt`, `busy` and the `mem_we`/`mem_re` command are high.
- Write: committed at the end of cycle 1; back in IDLE in cycle 2. Throughput is 1 write per 2 cycles.
- Read: `mem_out` is valid in cycle 2 (RDATA); `rvalid` and `rdata` appear in cycle 3. Throughput is 1 read per 3 cycles.
- The IDLE cycle in which the next winner is selected overlaps the `rvalid` cycle of the previous read.
- Address range 0x000-0xFFF is accepted without wrap or error; all four 1K banks are reachable.
- Asynchronous reset mid-operation (ACCESS or RDATA):
  - The FSM returns to IDLE immediately and all outputs go to 0.
  - The in-flight read produces no `rvalid`.
  - An in-flight write may or may not have been committed.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin arbitration.
  - A last-grant register resets to 1, so port 0 wins the first contention.
  - When both ports request in IDLE, grant the port not granted last.
  - A single requester is always granted, and this updates the last-grant register.
- `MEM_ARB_RR_EN` undefined: fixed priority. Port 0 always wins contention; no last-grant register exists.

## Test plan
- Port 0 writes 0xA1 to 0x000, then reads 0x000 -> `p0_gnt` 1 cycle after `req`; `p0_rvalid` 3 cycles after read `req` with `p0_rdata` = 0xA1; `p1_rdata` stays 0.
- Port 1 writes 0xD3 to 0xFFF, then reads 0xFFF and 0x400 (preloaded 0xB1) back-to-back -> `p1_rdata` 0xD3 then 0xB1. `rvalid` pulses are 3 cycles apart. `busy` is low only in IDLE cycles.
- Both ports continuously request reads with `MEM_ARB_RR_EN` defined -> grants alternate 0,1,0,1. The first grant goes to port 0.
- Same stimulus with `MEM_ARB_RR_EN` undefined -> port 0 receives every grant while it keeps requesting. Port 1 is granted only after `p0_req` drops.
- Assert `rst_n` low during RDATA of a port 0 read -> all outputs are 0 within the reset cycle. No `p0_rvalid` appears. After release, the FSM is in IDLE and a new read from 0x200 returns the stored 0xA2.
- Port 0 read and port 1 write to the same address (0x600) arrive together (RR) -> the port 0 read completes first with the old value. The port 1 write follows. A later read returns the new value.
